// File: rtl/sevenseg_event_scheduler.sv
// sevenseg_event_scheduler: round-robin L/C/R display scheduler with sticky overcurrent alarm; define OC_BLINK_EN to blink the alarm code
module sevenseg_event_scheduler #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W = 26
`ifdef OC_BLINK_EN
  , parameter int BLINK_CYCLES = 25_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       oc_clear,
  output logic [3:0] code,
  output logic       busy,
  output logic       alarm
);
  typedef enum logic [1:0] {IDLE, SHOW, ALARM} state_t;
  state_t state;
  logic [3:0] req_q, edg;
  logic oc_q, take;
  logic [2:0] pending, pr, clr;
  logic [1:0] ptr, p1, p2, sel;
  logic [CNT_W-1:0] hold;
`ifdef OC_BLINK_EN
  logic [CNT_W-1:0] blink;
`endif
  assign edg = req & ~req_q;
  // pr is pending re-indexed by pointer position: 0=L, 1=C, 2=R
  always_comb begin
    pr = {pending[0], pending[1], pending[2]};
    p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    sel = pr[ptr] ? ptr : pr[p1] ? p1 : p2;
    take = |pending && !oc_q && (state == IDLE || (state == SHOW && hold == '0));
    clr = take ? 3'b100 >> sel : 3'b000;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      code <= '0;
      busy <= 1'b0;
      alarm <= 1'b0;
      req_q <= '0;
      oc_q <= 1'b0;
      pending <= '0;
      ptr <= '0;
      hold <= '0;
`ifdef OC_BLINK_EN
      blink <= '0;
`endif
    end else begin
      req_q <= req;
      oc_q <= edg[0];
      pending <= (pending & ~clr) | edg[3:1];
      if (take) begin
        state <= SHOW;
        code <= 4'b1000 >> sel;
        busy <= 1'b1;
        ptr <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
        hold <= CNT_W'(HOLD_CYCLES - 1);
      end else if (oc_q && state != ALARM) begin
        state <= ALARM;
        code <= 4'b0001;
        busy <= 1'b1;
        alarm <= 1'b1;
        hold <= '0;
`ifdef OC_BLINK_EN
        blink <= CNT_W'(BLINK_CYCLES - 1);
`endif
      end else if (state == SHOW) begin
        if (hold == '0) begin
          state <= IDLE;
          code <= '0;
          busy <= 1'b0;
        end else hold <= hold - CNT_W'(1);
      end else if (state == ALARM) begin
        if (oc_clear && !req[0]) begin
          state <= IDLE;
          code <= '0;
          busy <= 1'b0;
          alarm <= 1'b0;
        end
`ifdef OC_BLINK_EN
        else if (blink == '0) begin
          blink <= CNT_W'(BLINK_CYCLES - 1);
          code <= code ^ 4'b0001;
        end else blink <= blink - CNT_W'(1);
`endif
      end
    end
endmodule

// File: tb/tb_sevenseg_event_scheduler.sv
// tb_sevenseg_event_scheduler: randomized and directed bench against an event-level reference model
module tb_sevenseg_event_scheduler;
  localparam int H = 4;
  localparam int B = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic oc_clear = 1'b0;
  logic [3:0] code;
  logic busy, alarm;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sevenseg_event_scheduler #(
    .HOLD_CYCLES(H),
    .CNT_W(8)
`ifdef OC_BLINK_EN
    , .BLINK_CYCLES(B)
`endif
  ) dut (.clk(clk), .rst(rst), .req(req), .oc_clear(oc_clear), .code(code), .busy(busy), .alarm(alarm));
  // reference: mode 0=idle 1=showing 2=alarm; pend/next indexed 0=L 1=C 2=R
  int m_mode = 0;
  int m_left = 0;
  int m_acnt = 0;
  int m_next = 0;
  logic [2:0] m_pend = '0;
  logic [3:0] m_prev = '0;
  logic m_ocd = 1'b0;
  logic [3:0] m_code = '0;
  always @(posedge clk) begin : model
    logic [3:0] e;
    int pick;
    e = req & ~m_prev;
    if (rst) begin
      m_mode = 0; m_left = 0; m_acnt = 0; m_next = 0;
      m_pend = '0; m_prev = '0; m_ocd = 1'b0; m_code = '0;
    end else begin
      pick = -1;
      if (m_mode != 2 && m_ocd) begin
        m_mode = 2; m_code = 4'b0001; m_acnt = 0;
      end else if ((m_mode == 0 || (m_mode == 1 && m_left == 1)) && m_pend != 0) begin
        for (int k = 0; k < 3; k++)
          if (pick < 0 && m_pend[(m_next + k) % 3]) pick = (m_next + k) % 3;
        m_pend[pick] = 1'b0;
        m_code = 4'b1000 >> pick;
        m_left = H;
        m_next = (pick + 1) % 3;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_left == 1) begin m_mode = 0; m_code = '0; end
        else m_left--;
      end else if (m_mode == 2) begin
        if (oc_clear && !req[0]) begin m_mode = 0; m_code = '0; end
        else begin
          m_acnt++;
`ifdef OC_BLINK_EN
          m_code = ((m_acnt / B) % 2 == 0) ? 4'b0001 : 4'b0000;
`endif
        end
      end
      m_pend |= {e[1], e[2], e[3]};
      m_ocd = e[0];
      m_prev = req;
    end
  end
  task automatic cyc(input logic [3:0] r, input logic c);
    req = r;
    oc_clear = c;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    checks++;
    if ({code, busy, alarm} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL reset: code=%b busy=%b alarm=%b want 0000 0 0", code, busy, alarm);
    end
    rst = 1'b0;
    cyc(4'b0000, 1'b0);
  endtask
  task automatic test_single;
    logic [3:0] want [6] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
    int nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i == 0 ? 4'b1000 : 4'b0000, 1'b0);
      nbusy += busy;
      checks++;
      if (code !== want[i] || code !== m_code) begin
        errors++;
        $display("FAIL single[%0d]: code=%b want %b (model %b)", i, code, want[i], m_code);
      end
    end
    cyc(4'b0000, 1'b0);
    nbusy += busy;
    checks++;
    if (nbusy != H) begin
      errors++;
      $display("FAIL single_busy: busy cycles=%0d want %0d", nbusy, H);
    end
  endtask
  task automatic test_multi;
    logic [3:0] want [15] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h4, 4'h4, 4'h4, 4'h4,
                              4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    rst = 1'b1; cyc(4'b0000, 1'b0); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(i == 0 ? 4'b1110 : 4'b0000, 1'b0);
      checks++;
      if (code !== want[i] || busy !== (want[i] != 0)) begin
        errors++;
        $display("FAIL multi[%0d]: code=%b busy=%b want %b", i, code, busy, want[i]);
      end
    end
  endtask
  task automatic test_pointer;
    logic [3:0] want [10] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
    rst = 1'b1; cyc(4'b0000, 1'b0); rst = 1'b0;
    cyc(4'b0100, 1'b0);
    for (int i = 0; i < 6; i++) cyc(4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(i == 0 ? 4'b1010 : 4'b0000, 1'b0);
      checks++;
      if (code !== want[i]) begin
        errors++;
        $display("FAIL pointer[%0d]: code=%b want %b", i, code, want[i]);
      end
    end
  endtask
  task automatic test_alarm;
    rst = 1'b1; cyc(4'b0000, 1'b0); rst = 1'b0;
    cyc(4'b0100, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    checks++;
    if (code !== 4'b0100 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_pre: code=%b alarm=%b want 0100 0", code, alarm);
    end
    cyc(4'b1001, 1'b0);
    checks++;
    if (code !== 4'b0001 || alarm !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL alarm_enter: code=%b alarm=%b busy=%b want 0001 1 1", code, alarm, busy);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, 1'b1);
      checks++;
      if (alarm !== 1'b1 || {code, busy} !== {m_code, 1'b1}) begin
        errors++;
        $display("FAIL alarm_sticky[%0d]: code=%b alarm=%b want %b 1", i, code, alarm, m_code);
      end
    end
    cyc(4'b0000, 1'b1);
    checks++;
    if ({code, busy, alarm} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL alarm_exit: code=%b busy=%b alarm=%b want 0000 0 0", code, busy, alarm);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0000, 1'b0);
      checks++;
      if (code !== 4'b1000) begin
        errors++;
        $display("FAIL alarm_after[%0d]: code=%b want 1000", i, code);
      end
      if (i == 3) i = 6;
    end
  endtask
  task automatic test_rst_mid;
    rst = 1'b1; cyc(4'b0000, 1'b0); rst = 1'b0;
    cyc(4'b1110, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    rst = 1'b1;
    cyc(4'b0000, 1'b0);
    rst = 1'b0;
    checks++;
    if ({code, busy, alarm} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL rst_mid: code=%b busy=%b alarm=%b want 0000 0 0", code, busy, alarm);
    end
    for (int i = 0; i < 15; i++) begin
      cyc(4'b0000, 1'b0);
      checks++;
      if (code !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_quiet[%0d]: code=%b busy=%b want 0000 0", i, code, busy);
      end
    end
  endtask
`ifdef OC_BLINK_EN
  task automatic test_blink;
    logic [3:0] want [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    rst = 1'b1; cyc(4'b0000, 1'b0); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0001, 1'b0);
      checks++;
      if (code !== want[i] || alarm !== (i != 0)) begin
        errors++;
        $display("FAIL blink[%0d]: code=%b alarm=%b want %b %b", i, code, alarm, want[i], i != 0);
      end
    end
    cyc(4'b0000, 1'b1);
  endtask
`endif
  task automatic test_random;
    logic [3:0] r = '0;
    rst = 1'b1; cyc(4'b0000, 1'b0); rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 1; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 19) == 0) r[0] = ~r[0];
      rst = ($urandom_range(0, 99) == 0);
      cyc(r, $urandom_range(0, 3) == 0);
      checks++;
      if ({code, busy, alarm} !== {m_code, m_mode != 0, m_mode == 2}) begin
        errors++;
        $display("FAIL random[%0d]: code=%b busy=%b alarm=%b want %b %b %b",
                 i, code, busy, alarm, m_code, m_mode != 0, m_mode == 2);
      end
    end
    rst = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_pointer();
    test_alarm();
    test_rst_mid();
`ifdef OC_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
